// File: rtl/nec_ir_tx_if.sv
// nec_ir_tx_if: request/status bundle for the NEC IR transmitter.
//   tx_start  : request pulse, honoured only while busy=0
//   tx_repeat : 1 = repeat code, 0 = data frame (sampled with tx_start)
//   tx_addr   : address byte captured on accept
//   tx_data   : command byte captured on accept
//   busy      : transmitter owns the line (accept cycle through guard gap)
//   tx_done   : one-cycle pulse at the end of the guard gap
// modport master drives requests; modport slave is the transmitter side.
interface nec_ir_tx_if;
  logic       tx_start;
  logic       tx_repeat;
  logic [7:0] tx_addr;
  logic [7:0] tx_data;
  logic       busy;
  logic       tx_done;

  modport master (
    output tx_start, tx_repeat, tx_addr, tx_data,
    input  busy, tx_done
  );

  modport slave (
    input  tx_start, tx_repeat, tx_addr, tx_data,
    output busy, tx_done
  );
endinterface

// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC infrared transmitter. Emits a 32-bit NEC frame
// ({~cmd, cmd, ~addr, addr}, LSB first) or an NEC repeat code, each followed
// by a guard gap of GAP_UNITS units.
// Ports:
//   sys_clk   : clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : nec_ir_tx_if.slave (tx_start/tx_repeat/tx_addr/tx_data in,
//               busy/tx_done out)
//   ir_out    : demodulated active-low envelope (0 = mark, 1 = space/idle)
//   ir_led    : LED drive
// Build option: define NEC_TX_CARRIER_EN to modulate ir_led with a carrier of
// CARRIER_CYC cycles (high for the first half) during marks; otherwise
// ir_led is the inverted envelope.
module nec_ir_tx #(
  parameter int unsigned UNIT_CYC    = 28125,
  parameter int unsigned GAP_UNITS   = 64,
  parameter int unsigned CARRIER_CYC = 1316
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  nec_ir_tx_if.slave  bus,
  output logic        ir_out,
  output logic        ir_led
);

  localparam int unsigned UW   = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int unsigned MAXU = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int unsigned DW   = $clog2(MAXU);

  if (CARRIER_CYC < 2 || UNIT_CYC < 1 || GAP_UNITS < 1) begin : g_bad_param
    $error("nec_ir_tx: CARRIER_CYC must be >= 2, UNIT_CYC and GAP_UNITS >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [DW-1:0] last_unit;
  logic [31:0]   shift_q, shift_d;
  logic [5:0]    bit_q, bit_d;
  logic          rpt_q, rpt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ir_out_q, ir_out_d;
  logic          accept;

  assign accept      = bus.tx_start && !busy_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;
  assign ir_out      = ir_out_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      unit_q   <= '0;
      dur_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      rpt_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ir_out_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      unit_q   <= unit_d;
      dur_q    <= dur_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      rpt_q    <= rpt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ir_out_q <= ir_out_d;
    end
  end

  // Index of the last unit of the current state (state length minus one).
  always_comb begin
    last_unit = '0;
    case (state_q)
      S_LEAD_MARK:  last_unit = DW'(15);
      S_LEAD_SPACE: last_unit = rpt_q ? DW'(3) : DW'(7);
      S_BIT_SPACE:  last_unit = shift_q[0] ? DW'(2) : DW'(0);
      S_GAP:        last_unit = DW'(GAP_UNITS - 1);
      default:      last_unit = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    dur_d   = dur_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    rpt_d   = rpt_q;
    done_d  = 1'b0;

    if (state_q == S_IDLE) begin
      if (accept) begin
        state_d = S_LEAD_MARK;
        shift_d = {~bus.tx_data, bus.tx_data, ~bus.tx_addr, bus.tx_addr};
        rpt_d   = bus.tx_repeat;
        unit_d  = '0;
        dur_d   = '0;
        bit_d   = '0;
      end
    end else if (unit_q == UW'(UNIT_CYC - 1)) begin
      unit_d = '0;
      if (dur_q == last_unit) begin
        dur_d = '0;
        case (state_q)
          S_LEAD_MARK:  state_d = S_LEAD_SPACE;
          S_LEAD_SPACE: state_d = rpt_q ? S_STOP_MARK : S_BIT_MARK;
          S_BIT_MARK:   state_d = S_BIT_SPACE;
          S_BIT_SPACE: begin
            shift_d = {1'b0, shift_q[31:1]};
            bit_d   = bit_q + 6'd1;
            state_d = (bit_q == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
          end
          S_STOP_MARK:  state_d = S_GAP;
          S_GAP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default:      state_d = S_IDLE;
        endcase
      end else begin
        dur_d = dur_q + DW'(1);
      end
    end else begin
      unit_d = unit_q + UW'(1);
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register.
    ir_out_d = !(state_d == S_LEAD_MARK || state_d == S_BIT_MARK ||
                 state_d == S_STOP_MARK);
    busy_d   = (state_d != S_IDLE);
  end

`ifdef NEC_TX_CARRIER_EN
  localparam int unsigned CW = $clog2(CARRIER_CYC);

  logic [CW-1:0] car_q, car_d;
  logic          led_q, led_d;

  // Carrier phase restarts on every space-to-mark transition so each mark
  // begins with a high half-period.
  always_comb begin
    if (!ir_out_d && ir_out_q)             car_d = '0;
    else if (car_q == CW'(CARRIER_CYC - 1)) car_d = '0;
    else                                   car_d = car_q + CW'(1);
    led_d = !ir_out_d && (car_d < CW'(CARRIER_CYC / 2));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      car_q <= '0;
      led_q <= 1'b0;
    end else begin
      car_q <= car_d;
      led_q <= led_d;
    end
  end

  assign ir_led = led_q;
`else
  assign ir_led = ~ir_out_q;
`endif

endmodule

// File: doc/nec_ir_tx.md
# nec_ir_tx

NEC-format infrared transmitter: on request it emits a full 32-bit NEC frame (address, ~address, command, ~command, LSB first) or an NEC repeat code. It is the transmit-side counterpart of the board's IR receive path. `ir_out` carries the demodulated, active-low envelope, matching an IR receiver module's output, so it can be looped straight into the receive logic. Optionally, `ir_led` carries a 38 kHz-modulated drive for an IR LED.

## Interface
- `UNIT_CYC`, default 28125: sys_clk cycles per NEC unit of 562.5 us at 50 MHz.
- `GAP_UNITS`, default 64: idle units appended after every frame or repeat code (36 ms guard).
- `CARRIER_CYC`, default 1316: sys_clk cycles per carrier period (about 38 kHz).
- `sys_clk` in, 1 bit: clock.
- `sys_rst_n` in, 1 bit: reset, asynchronous, active-low.
- `tx_start` in, 1 bit: request pulse, sampled only while `busy`=0.
- `tx_repeat` in, 1 bit: sampled with `tx_start`; 1 = send repeat code, 0 = send data frame.
- `tx_addr` in, 8 bits: address byte, captured on accepted `tx_start`.
- `tx_data` in, 8 bits: command byte, captured on accepted `tx_start`.
- `busy` out, 1 bit: high from the accept cycle through the end of the guard gap.
- `tx_done` out, 1 bit: one-cycle pulse at the end of the guard gap.
- `ir_out` out, 1 bit: envelope; 0 = mark, 1 = space/idle.
- `ir_led` out, 1 bit: LED drive; see Configuration.

## Operation
- A unit counter counts 0..UNIT_CYC-1. A duration counter counts units within the current state. Each state lasts an exact integer number of units.
- Accept: `tx_start`=1 and `busy`=0. On accept, load shift register {~tx_data, tx_data, ~tx_addr, tx_addr}, latch `tx_repeat`, and clear the counters. `tx_start` while `busy`=1 is ignored, and no captured value changes.
- FSM states and transitions:
  - IDLE, `ir_out`=1 -> LEAD_MARK on accept.
  - LEAD_MARK: 16 units, `ir_out`=0 -> LEAD_SPACE.
  - LEAD_SPACE: 8 units for a frame, 4 units for a repeat, `ir_out`=1. Then frame -> BIT_MARK, repeat -> STOP_MARK.
  - BIT_MARK: 1 unit, `ir_out`=0 -> BIT_SPACE.
  - BIT_SPACE: 1 unit if shift[0]=0, 3 units if shift[0]=1, `ir_out`=1. On exit, shift right and increment the bit count (0..31). Count 31 -> STOP_MARK, else -> BIT_MARK.
  - STOP_MARK: 1 unit, `ir_out`=0 -> GAP.
  - GAP: GAP_UNITS units, `ir_out`=1 -> IDLE, pulsing `tx_done`.
- The bit counter is 6 bits wide and is cleared on accept. It never wraps mid-frame.
- Total data-frame length is 16+8+Σbits+1+GAP_UNITS units. Each bit is 2 units (0) or 4 units (1). Repeat-code length is 16+4+1+GAP_UNITS units.

## Timing
- Reset values: `ir_out`=1, `ir_led`=0, `busy`=0, `tx_done`=0, FSM=IDLE, all counters and the shift register 0.
- All outputs are registered. Accept at edge N -> `busy`=1 and `ir_out`=0 from edge N+1.
- Every `ir_out` level lasts exactly units×UNIT_CYC cycles, with no ±1 slip between states.
- `tx_done`=1 and `busy`=0 start in the same cycle. A new `tx_start` in that cycle is accepted, giving back-to-back frames separated only by the gap.
- Reset mid-frame forces the reset values immediately (asynchronously). No partial frame resumes after reset release.

## Configuration
- Macro `NEC_TX_CARRIER_EN`.
- Defined: during marks, `ir_led` is a carrier that is high for the first CARRIER_CYC/2 cycles of each CARRIER_CYC period. The carrier counter restarts at every mark start, so each mark begins high. During spaces/idle, `ir_led`=0.
- Undefined: no carrier logic is built and `ir_led` = ~`ir_out` (unmodulated envelope).

## Test plan
- Use UNIT_CYC=8, GAP_UNITS=4, CARRIER_CYC=4 for all scenarios except the last.
- Frame: tx_addr=0x00, tx_data=0x45, tx_repeat=0 -> low 128 cycles, high 64 cycles. Then 32 bits encoding 0x00,0xFF,0x45,0xBA LSB first: 0-bits show high 8 cycles, 1-bits high 24 cycles, each bit preceded by low 8 cycles. Then stop low 8, gap 32, then a single `tx_done`.
- Repeat: tx_repeat=1 -> low 128, high 32, low 8, high 32, `tx_done`; the shift register is unused.
- Busy reject: second `tx_start` with tx_data=0x12 mid-frame -> the frame still carries 0x45 and no extra frame follows. A `tx_start` in the `tx_done` cycle -> the next frame starts on the following cycle.
- Reset mid-frame during BIT_SPACE -> `ir_out`=1 and `busy`=0 immediately. After release, IDLE persists until the next `tx_start`.
- With `NEC_TX_CARRIER_EN`: each mark shows `ir_led` toggling at a 2-high/2-low pattern, starting high, and `ir_led`=0 in spaces. Without the macro: `ir_led`=~`ir_out` at all times.
- Loopback at default parameters: feed `ir_out` into the team's IR receiver with tx_data=0xA5 -> receiver reports data 0xA5 with data valid once. A subsequent repeat request -> receiver reports repeat valid once.
